// File: rtl/led_pkg.sv
// Shared types and constants for the RGB LED blocks.
// Latency: n/a (declarations only); backpressure: n/a.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int LED_R = 0;
   localparam int LED_G = 1;
   localparam int LED_B = 2;

   localparam logic MODE_SOLID = 1'b0;
   localparam logic MODE_BLINK = 1'b1;

   function automatic logic [2:0] led_mask(input logic [2:0] col, input logic md, input logic ph);
      logic [2:0] m;
      m = col;
      case (md)
         MODE_SOLID: m = col;
         MODE_BLINK: m = col & {3{ph}};
         default:    m = col;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rgb_led_arbiter_if.sv
// Request/grant bundle between LED requesters and the RGB LED arbiter.
// Latency: n/a; backpressure: none, requests are level-held until granted.
interface rgb_led_arbiter_if #(parameter int N = 3);

   logic [N-1:0]   req;
   logic [3*N-1:0] color;
   logic [N-1:0]   mode;
   logic [N-1:0]   grant;
   logic [N-1:0]   ack;
   logic           redled;
   logic           greenled;
   logic           blueled;
   logic           blink;
   logic           busy;

   modport master (
      output req, color, mode,
      input  grant, ack, redled, greenled, blueled, blink, busy
   );

   modport slave (
      input  req, color, mode,
      output grant, ack, redled, greenled, blueled, blink, busy
   );

endinterface

// File: rtl/led_blink_gen.sv
// Free-running square wave, toggling every BLINK_HALF cycles, low first.
// Latency: registered output; backpressure: none, never stalls.
module led_blink_gen #(
   parameter int BLINK_HALF = 6000000
) (
   input  logic clk,
   input  logic reset,
   output logic phase
);

   localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == CW'(BLINK_HALF - 1)) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin sharing of one RGB LED among N requesters with min hold and off gap.
// Latency: 1 cycle from winning edge to outputs; backpressure: losers keep req high and wait.
module rgb_led_arbiter #(
   parameter int N           = 3,
   parameter int HOLD_CYCLES = 24000000,
   parameter int GAP_CYCLES  = 2400000,
   parameter int BLINK_HALF  = 6000000
) (
   input  logic              clk,
   input  logic              reset,
   rgb_led_arbiter_if.slave  bus
);

   import led_pkg::*;

   localparam int PW = $clog2(N);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t        state, state_n;
   logic [PW-1:0] ptr, ptr_n;
   logic [HW-1:0] hold, hold_n;
   logic [GW-1:0] gap, gap_n;
   logic [2:0]    col, col_n;
   logic          md, md_n;
   logic [N-1:0]  grant_q, grant_n;
   logic [N-1:0]  ack_q, ack_n;
   logic [2:0]    led_q, led_n;
   logic          busy_q, busy_n;
   logic          phase;
   logic [PW:0]   pick;
   logic          found;
   logic [PW-1:0] win;
   logic [2:0]    win_col;
   logic [2:0]    own_col;
   logic          arb;

   // Nearest set bit after p wins; scanning far-to-near lets the nearest overwrite.
   function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
      logic [PW:0] res;
      int          j;
      res = '0;
      for (int k = N; k >= 1; k--) begin
         j = (int'(p) + k) % N;
         if (r[PW'(j)]) res = {1'b1, PW'(j)};
      end
      return res;
   endfunction

   led_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
      .clk   (clk),
      .reset (reset),
      .phase (phase)
   );

   assign pick    = rr_pick(bus.req, ptr);
   assign found   = pick[PW];
   assign win     = pick[PW-1:0];
   assign win_col = bus.color[3*int'(win) +: 3];
   assign own_col = bus.color[3*int'(ptr) +: 3];
   assign arb     = (state == IDLE) || ((state == GAP) && (gap == '0));

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hold_n  = hold;
      gap_n   = gap;
      col_n   = col;
      md_n    = md;
      grant_n = grant_q;
      ack_n   = '0;
      led_n   = '0;
      busy_n  = busy_q;

      case (state)
         SHOW: begin
            if (hold != '0) begin
               hold_n = hold - HW'(1);
               led_n  = led_mask(col, md, phase);
            end else if (bus.req == grant_q) begin
               // Sole remaining requester keeps the LED and picks up its current colour.
               hold_n = HW'(HOLD_CYCLES - 1);
               col_n  = own_col;
               md_n   = bus.mode[ptr];
               led_n  = led_mask(own_col, bus.mode[ptr], phase);
            end else begin
               state_n = GAP;
               grant_n = '0;
               gap_n   = GW'(GAP_CYCLES - 1);
            end
         end
         GAP: begin
            if (gap != '0) gap_n = gap - GW'(1);
         end
         default: ;
      endcase

      if (arb) begin
         if (found) begin
            state_n = SHOW;
            ptr_n   = win;
            hold_n  = HW'(HOLD_CYCLES - 1);
            col_n   = win_col;
            md_n    = bus.mode[win];
            grant_n = {{(N-1){1'b0}}, 1'b1} << win;
            ack_n   = {{(N-1){1'b0}}, 1'b1} << win;
            led_n   = led_mask(win_col, bus.mode[win], phase);
            busy_n  = 1'b1;
         end else begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         ptr     <= PW'(N - 1);
         hold    <= '0;
         gap     <= '0;
         col     <= '0;
         md      <= 1'b0;
         grant_q <= '0;
         ack_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         hold    <= hold_n;
         gap     <= gap_n;
         col     <= col_n;
         md      <= md_n;
         grant_q <= grant_n;
         ack_q   <= ack_n;
         led_q   <= led_n;
         busy_q  <= busy_n;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.ack      = ack_q;
   assign bus.redled   = led_q[LED_R];
   assign bus.greenled = led_q[LED_G];
   assign bus.blueled  = led_q[LED_B];
   assign bus.busy     = busy_q;
   assign bus.blink    = phase;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with N=3, HOLD=4, GAP=2, BLINK_HALF=3.
module tb_rgb_led_arbiter;

   localparam int N    = 3;
   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int BH   = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // Reference heartbeat: toggles every BH cycles, low first after reset.
   logic [1:0] bcnt;
   logic       bph;
   logic       bph_prev;

   rgb_led_arbiter_if #(.N(N)) bus();

   rgb_led_arbiter #(
      .N           (N),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .BLINK_HALF  (BH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bph_prev <= bph;
      if (!reset) begin
         bcnt <= 2'd0;
         bph  <= 1'b0;
      end else if (bcnt == 2'(BH - 1)) begin
         bcnt <= 2'd0;
         bph  <= ~bph;
      end else begin
         bcnt <= bcnt + 2'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] leds();
      return {bus.blueled, bus.greenled, bus.redled};
   endfunction

   task automatic chk_out(input string tag, input logic [2:0] g, input logic [2:0] a,
                          input logic [2:0] l, input logic b);
      chk({tag, "_grant"}, bus.grant, g);
      chk({tag, "_ack"},   bus.ack,   a);
      chk({tag, "_led"},   leds(),    l);
      chk({tag, "_busy"},  bus.busy,  b);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rr_g [4];
      logic [2:0] rr_l [4];
      int         highs;
      rr_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      rr_l = '{3'b000, 3'b010, 3'b100, 3'b001};

      reset     = 1'b0;
      bus.req   = 3'b111;
      bus.color = 9'b000_000_000;
      bus.mode  = 3'b000;

      // Reset held for two edges with every requester asking.
      tick(2);
      chk_out("reset", 3'b000, 3'b000, 3'b000, 1'b0);
      chk("reset_blink", bus.blink, 1'b0);
      reset = 1'b1;
      tick(1);

      // Round robin; requester 0 first with colour 000, then live colours change.
      for (int gi = 0; gi < 4; gi++) begin
         for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
               chk("rr_grant", bus.grant, rr_g[gi]);
               chk("rr_ack",   bus.ack,   (c == 0) ? rr_g[gi] : 3'b000);
               chk("rr_led",   leds(),    rr_l[gi]);
            end else begin
               chk("rr_gap_grant", bus.grant, 3'b000);
               chk("rr_gap_led",   leds(),    3'b000);
            end
            chk("rr_busy",  bus.busy,  1'b1);
            chk("rr_blink", bus.blink, bph);
            if (gi == 0 && c == 0) bus.color = 9'b100_010_001;
            tick(1);
         end
      end
      chk_out("rr5", 3'b010, 3'b010, 3'b010, 1'b1);
      bus.req = 3'b000;
      tick(3);
      chk_out("rr5_last", 3'b010, 3'b000, 3'b010, 1'b1);
      tick(1);
      chk_out("drain_gap1", 3'b000, 3'b000, 3'b000, 1'b1);
      tick(1);
      chk_out("drain_gap2", 3'b000, 3'b000, 3'b000, 1'b1);
      tick(1);
      chk_out("drain_idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Lone solid requester: extends without a new ack, re-latching its colour.
      bus.req   = 3'b010;
      bus.color = 9'b100_101_001;
      tick(1);
      chk_out("solo_c1", 3'b010, 3'b010, 3'b101, 1'b1);
      bus.color = 9'b100_011_001;
      for (int c = 2; c <= 8; c++) begin
         tick(1);
         chk_out("solo_show", 3'b010, 3'b000, (c <= 4) ? 3'b101 : 3'b011, 1'b1);
         if (c == 5) bus.req = 3'b000;
      end
      tick(1);
      chk_out("solo_gap1", 3'b000, 3'b000, 3'b000, 1'b1);
      tick(1);
      chk_out("solo_gap2", 3'b000, 3'b000, 3'b000, 1'b1);
      tick(1);
      chk_out("solo_idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Blink mode, white, held over three hold periods.
      bus.req   = 3'b001;
      bus.mode  = 3'b001;
      bus.color = 9'b100_011_111;
      highs     = 0;
      for (int c = 1; c <= 12; c++) begin
         tick(1);
         chk("blink_grant", bus.grant, 3'b001);
         chk("blink_ack",   bus.ack,   (c == 1) ? 3'b001 : 3'b000);
         chk("blink_led",   leds(),    {3{bph_prev}});
         chk("blink_out",   bus.blink, bph);
         if (leds() == 3'b111) highs++;
         if (c == 9) bus.req = 3'b000;
      end
      chk("blink_high_count", highs, 6);
      bus.mode = 3'b000;
      tick(2);
      chk_out("blink_gap2", 3'b000, 3'b000, 3'b000, 1'b1);
      tick(1);
      chk_out("blink_idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Early release plus colour change during SHOW; hold is not shortened.
      bus.req   = 3'b001;
      bus.color = 9'b100_011_110;
      tick(1);
      chk_out("early_c1", 3'b001, 3'b001, 3'b110, 1'b1);
      bus.req   = 3'b000;
      bus.color = 9'b100_011_001;
      for (int c = 2; c <= 4; c++) begin
         tick(1);
         chk_out("early_show", 3'b001, 3'b000, 3'b110, 1'b1);
      end
      tick(1);
      chk_out("early_gap1", 3'b000, 3'b000, 3'b000, 1'b1);
      tick(2);
      chk_out("early_idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Reset in the middle of SHOW; pointer returns to favour requester 0.
      bus.req   = 3'b010;
      bus.color = 9'b100_111_001;
      tick(1);
      chk_out("mid_c1", 3'b010, 3'b010, 3'b111, 1'b1);
      tick(1);
      chk("mid_c2_grant", bus.grant, 3'b010);
      reset   = 1'b0;
      bus.req = 3'b011;
      tick(1);
      chk_out("mid_reset", 3'b000, 3'b000, 3'b000, 1'b0);
      chk("mid_reset_blink", bus.blink, 1'b0);
      reset = 1'b1;
      tick(1);
      chk_out("mid_after", 3'b001, 3'b001, 3'b001, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
